// File: rtl/chan_tx_scheduler_pkg.sv
// Shared constants for the TX scheduler: state encoding, sample and owner widths, clog2 helper.
package tx_sched_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned OWNER_W  = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARB   = 2'd1;
   localparam logic [1:0] ST_OWN   = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/chan_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1 (mod NCH).
module rr_pick
   import tx_sched_pkg::*;
#(
   parameter int unsigned NCH = 2
) (
   input  logic [NCH-1:0]     req,
   input  logic [OWNER_W-1:0] last,
   output logic [OWNER_W-1:0] grant_idx,
   output logic               any
);

   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      for (int unsigned off = 1; off <= NCH; off++) begin
         for (int unsigned k = 0; k < NCH; k++) begin
            if (!any && req[k] && (k == (32'(last) + off) % NCH)) begin
               grant_idx = OWNER_W'(k);
               any       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/chan_tx_scheduler.sv
// Shares one TX chain between NCH channel readers with round-robin burst grants and guard gaps.
// Optional stuck-owner watchdog enabled by `define TX_SCHED_WDOG_EN.
module chan_tx_scheduler
   import tx_sched_pkg::*;
#(
   parameter int unsigned NCH          = 2,
   parameter int unsigned WDOG_STROBES = 1024
) (
   input  logic                    tx_clock,
   input  logic                    reset_n,
   input  logic                    tx_strobe,
   input  logic                    enable,
   input  logic [7:0]              guard_len,
   input  logic [NCH-1:0]          ch_req,
   input  logic [NCH-1:0]          ch_burst,
   input  logic [NCH-1:0]          ch_empty,
   input  logic [NCH*SAMPLE_W-1:0] ch_i,
   input  logic [NCH*SAMPLE_W-1:0] ch_q,
   output logic [NCH-1:0]          ch_strobe,
   output logic [SAMPLE_W-1:0]     tx_i,
   output logic [SAMPLE_W-1:0]     tx_q,
   output logic                    tx_active,
   output logic [OWNER_W-1:0]      owner,
   output logic [15:0]             underrun_cnt,
   output logic                    wdog_abort
);

   logic [1:0]          state;
   logic [7:0]          guard_left;
   logic                own_req, own_burst, own_empty;
   logic [SAMPLE_W-1:0] own_i, own_q;
   logic [OWNER_W-1:0]  pick_idx;
   logic                pick_any;
   logic                wdog_fire;
   logic                release_own;

   rr_pick #(.NCH(NCH)) u_pick (
      .req       (ch_req),
      .last      (owner),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   always_comb begin
      own_req   = 1'b0;
      own_burst = 1'b0;
      own_empty = 1'b0;
      own_i     = '0;
      own_q     = '0;
      ch_strobe = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (owner == OWNER_W'(k)) begin
            own_req      = ch_req[k];
            own_burst    = ch_burst[k];
            own_empty    = ch_empty[k];
            own_i        = ch_i[k*SAMPLE_W +: SAMPLE_W];
            own_q        = ch_q[k*SAMPLE_W +: SAMPLE_W];
            ch_strobe[k] = tx_strobe && (state == ST_OWN);
         end
      end
   end

   assign tx_active   = (state == ST_OWN);
   assign release_own = tx_active && tx_strobe &&
                        ((!own_burst && !own_req && own_empty) || wdog_fire);

   always_ff @(posedge tx_clock) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         owner        <= OWNER_W'(NCH - 1);
         guard_left   <= '0;
         underrun_cnt <= '0;
         tx_i         <= '0;
         tx_q         <= '0;
      end else begin
         tx_i <= '0;
         tx_q <= '0;
         case (state)
            ST_IDLE: if (enable && |ch_req) state <= ST_ARB;
            ST_ARB: begin
               if (pick_any) begin
                  owner <= pick_idx;
                  state <= ST_OWN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_OWN: begin
               if (!own_empty) begin
                  tx_i <= own_i;
                  tx_q <= own_q;
               end
               if (tx_strobe && own_burst && own_empty && underrun_cnt != '1)
                  underrun_cnt <= underrun_cnt + 16'd1;
               if (release_own) begin
                  guard_left <= guard_len;
                  state      <= (guard_len == '0) ? ST_IDLE : ST_GUARD;
               end
            end
            ST_GUARD: begin
               // guard_left holds the strobes still to be swallowed, latched on entry
               if (tx_strobe) begin
                  guard_left <= guard_left - 8'd1;
                  if (guard_left == 8'd1) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TX_SCHED_WDOG_EN
   logic [15:0] wdog_cnt;

   assign wdog_fire = tx_active && tx_strobe && own_empty &&
                      (wdog_cnt == 16'(WDOG_STROBES - 1));

   always_ff @(posedge tx_clock) begin
      if (!reset_n) begin
         wdog_cnt   <= '0;
         wdog_abort <= 1'b0;
      end else begin
         wdog_abort <= wdog_fire;
         if (!tx_active || wdog_fire)
            wdog_cnt <= '0;
         else if (tx_strobe)
            wdog_cnt <= own_empty ? wdog_cnt + 16'd1 : '0;
      end
   end
`else
   logic unused_wdog_cfg;
   assign unused_wdog_cfg = ^WDOG_STROBES;
   assign wdog_fire       = 1'b0;
   assign wdog_abort      = 1'b0;
`endif

endmodule

// File: tb/tb_chan_tx_scheduler.sv
// Self-checking bench for chan_tx_scheduler: directed scenarios plus random traffic vs a reference model.
module tb_chan_tx_scheduler;

   localparam int unsigned NCH = 2;
   localparam int unsigned WD  = 8;
   localparam int M_IDLE = 0, M_ARB = 1, M_OWN = 2, M_GUARD = 3;

   logic              tx_clock = 1'b0;
   logic              reset_n, tx_strobe, enable;
   logic [7:0]        guard_len;
   logic [NCH-1:0]    ch_req, ch_burst, ch_empty;
   logic [NCH*16-1:0] ch_i, ch_q;
   logic [NCH-1:0]    ch_strobe;
   logic [15:0]       tx_i, tx_q, underrun_cnt;
   logic              tx_active, wdog_abort;
   logic [2:0]        owner;

   chan_tx_scheduler #(.NCH(NCH), .WDOG_STROBES(WD)) dut (
      .tx_clock(tx_clock), .reset_n(reset_n), .tx_strobe(tx_strobe), .enable(enable),
      .guard_len(guard_len), .ch_req(ch_req), .ch_burst(ch_burst), .ch_empty(ch_empty),
      .ch_i(ch_i), .ch_q(ch_q), .ch_strobe(ch_strobe), .tx_i(tx_i), .tx_q(tx_q),
      .tx_active(tx_active), .owner(owner), .underrun_cnt(underrun_cnt), .wdog_abort(wdog_abort)
   );

   always #5 tx_clock = ~tx_clock;

   int checks = 0;
   int errors = 0;

   // reference model: phase of the scheduler and what the outputs should be
   int          m_phase, m_owner, m_under, m_guard_left, m_wd;
   logic [15:0] m_txi, m_txq;
   bit          m_abort;
   bit          m_valid = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NCH-1:0] es;
      if (!m_valid) return;
      es = '0;
      if (m_phase == M_OWN && tx_strobe) es[m_owner] = 1'b1;
      chk("ch_strobe", 32'(ch_strobe), 32'(es));
      chk("tx_active", 32'(tx_active), 32'(m_phase == M_OWN));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("tx_i", 32'(tx_i), 32'(m_txi));
      chk("tx_q", 32'(tx_q), 32'(m_txq));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
      chk("wdog_abort", 32'(wdog_abort), 32'(m_abort));
   endtask

   task automatic model_edge();
      logic [15:0] ni, nq;
      bit found, fire;
      int o;
      if (!reset_n) begin
         m_phase = M_IDLE; m_owner = NCH - 1; m_under = 0; m_guard_left = 0;
         m_wd = 0; m_txi = 0; m_txq = 0; m_abort = 0; m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      ni = 0; nq = 0; fire = 0; o = m_owner;
      case (m_phase)
         M_IDLE: if (enable && ch_req != 0) m_phase = M_ARB;
         M_ARB: begin
            found = 0;
            for (int off = 1; off <= NCH; off++) begin
               int c;
               c = (o + off) % NCH;
               if (!found && ch_req[c]) begin m_owner = c; found = 1; end
            end
            m_phase = found ? M_OWN : M_IDLE;
         end
         M_OWN: begin
            if (!ch_empty[o]) begin ni = ch_i[o*16 +: 16]; nq = ch_q[o*16 +: 16]; end
            if (tx_strobe && ch_burst[o] && ch_empty[o] && m_under < 65535) m_under++;
`ifdef TX_SCHED_WDOG_EN
            if (tx_strobe) begin
               if (ch_empty[o]) begin
                  m_wd++;
                  if (m_wd == WD) begin fire = 1; m_wd = 0; end
               end else m_wd = 0;
            end
`endif
            if (tx_strobe && ((!ch_burst[o] && !ch_req[o] && ch_empty[o]) || fire)) begin
               m_guard_left = guard_len;
               m_phase = (guard_len == 0) ? M_IDLE : M_GUARD;
               m_wd = 0;
            end
         end
         default: begin
            if (tx_strobe) begin
               m_guard_left--;
               if (m_guard_left == 0) m_phase = M_IDLE;
            end
         end
      endcase
      m_txi = ni; m_txq = nq; m_abort = fire;
   endtask

   task automatic cycle();
      #1;
      check_all();
      model_edge();
      @(negedge tx_clock);
   endtask

   task automatic set_in(input logic [NCH-1:0] r, input logic [NCH-1:0] b,
                         input logic [NCH-1:0] e, input logic s);
      ch_req = r; ch_burst = b; ch_empty = e; tx_strobe = s;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
   endtask

   logic [15:0] s_i;
   int grants[4];
   int ng, bcnt;
   bit was_active;

   initial begin
      reset_n = 1'b0; enable = 1'b0; guard_len = 8'd2;
      set_in('0, '0, '1, 1'b0);
      ch_i = '0; ch_q = '0;
      @(negedge tx_clock);
      cycle(); cycle();
      #1;
      chk("rst_owner", 32'(owner), NCH - 1);
      chk("rst_active", 32'(tx_active), 0);
      chk("rst_underrun", 32'(underrun_cnt), 0);

      // 1: lone ch0 request, 2 cycles to OWN, tx_i one cycle behind
      reset_n = 1'b1; enable = 1'b1; guard_len = 8'd2;
      set_in(2'b01, 2'b01, 2'b00, 1'b0);
      cycle(); cycle();
      ch_i = {$urandom, $urandom}; ch_q = {$urandom, $urandom};
      s_i = ch_i[15:0];
      tx_strobe = 1'b1;
      #1;
      chk("t1_active", 32'(tx_active), 1);
      chk("t1_strobe", 32'(ch_strobe), 32'b01);
      cycle();
      #1;
      chk("t1_txi", 32'(tx_i), 32'(s_i));
      set_in(2'b00, 2'b00, 2'b01, 1'b1);
      cycle();
      for (int n = 0; n < 4; n++) cycle();

      // 2: both channels keep requesting, grants alternate
      do_reset();
      enable = 1'b1; guard_len = 8'd2;
      ng = 0; bcnt = 0; was_active = 0;
      for (int n = 0; n < 200 && ng < 4; n++) begin
         set_in(2'b11, 2'b11, 2'b00, 1'b1);
         if (m_phase == M_OWN && bcnt == 3) begin
            ch_req[m_owner] = 1'b0; ch_burst[m_owner] = 1'b0; ch_empty[m_owner] = 1'b1;
         end
         ch_i = {$urandom, $urandom}; ch_q = {$urandom, $urandom};
         #1;
         if (tx_active && !was_active) begin grants[ng] = int'(owner); ng++; end
         was_active = tx_active;
         bcnt = (m_phase == M_OWN) ? bcnt + 1 : 0;
         cycle();
      end
      chk("t2_grant_count", ng, 4);
      for (int k = 0; k < ng; k++) chk("t2_grant_order", grants[k], k % 2);

      // 4: enable dropped mid-burst finishes the burst, pending req waits for enable
      do_reset();
      enable = 1'b1; guard_len = 8'd1;
      set_in(2'b01, 2'b01, 2'b00, 1'b1);
      for (int n = 0; n < 3; n++) cycle();
      enable = 1'b0;
      for (int n = 0; n < 3; n++) cycle();
      #1;
      chk("t4_burst_kept", 32'(tx_active), 1);
      set_in(2'b00, 2'b00, 2'b01, 1'b1);
      cycle();
      set_in(2'b01, 2'b01, 2'b00, 1'b1);
      for (int n = 0; n < 10; n++) cycle();
      #1;
      chk("t4_blocked", 32'(tx_active), 0);
      enable = 1'b1;
      cycle(); cycle();
      #1;
      chk("t4_regrant", 32'(tx_active), 1);

      // 5: reset during OWN
      cycle();
      reset_n = 1'b0;
      cycle();
      #1;
      chk("t5_strobe", 32'(ch_strobe), 0);
      chk("t5_active", 32'(tx_active), 0);
      chk("t5_owner", 32'(owner), NCH - 1);
      chk("t5_txi", 32'(tx_i), 0);
      chk("t5_txq", 32'(tx_q), 0);
      reset_n = 1'b1;

      // random traffic
      for (int n = 0; n < 2000; n++) begin
         reset_n   = ($urandom % 250) != 0;
         enable    = ($urandom % 8) != 0;
         guard_len = 8'($urandom % 4);
         set_in(NCH'($urandom), NCH'($urandom), NCH'($urandom & $urandom), ($urandom % 3) != 0);
         ch_i = {$urandom, $urandom}; ch_q = {$urandom, $urandom};
         cycle();
      end

`ifdef TX_SCHED_WDOG_EN
      // 6: stuck owner forced off after WD empty strobes
      do_reset();
      enable = 1'b1; guard_len = 8'd3;
      set_in(2'b01, 2'b01, 2'b00, 1'b0);
      cycle(); cycle();
      set_in(2'b01, 2'b01, 2'b01, 1'b1);
      for (int n = 0; n < WD; n++) cycle();
      #1;
      chk("t6_abort", 32'(wdog_abort), 1);
      chk("t6_released", 32'(tx_active), 0);
      cycle();
      #1;
      chk("t6_abort_pulse", 32'(wdog_abort), 0);
`endif

      // 3: ch1 underruns, then saturation
      do_reset();
      enable = 1'b1; guard_len = 8'd2;
      set_in(2'b10, 2'b10, 2'b11, 1'b0);
      ch_i = {$urandom, $urandom}; ch_q = {$urandom, $urandom};
      cycle(); cycle();
      tx_strobe = 1'b1;
      for (int n = 0; n < 5; n++) cycle();
      tx_strobe = 1'b0;
      #1;
      chk("t3_owner", 32'(owner), 1);
      chk("t3_underrun5", 32'(underrun_cnt), 5);
      chk("t3_txi_zero", 32'(tx_i), 0);
      chk("t3_txq_zero", 32'(tx_q), 0);
`ifndef TX_SCHED_WDOG_EN
      cycle();
      tx_strobe = 1'b1;
      for (int n = 0; n < 65529; n++) begin
         #1; model_edge(); @(negedge tx_clock);
      end
      #1;
      chk("t3_fffe", 32'(underrun_cnt), 32'hFFFE);
      for (int n = 0; n < 3; n++) cycle();
      #1;
      chk("t3_saturated", 32'(underrun_cnt), 32'hFFFF);
      for (int n = 0; n < 20; n++) cycle();
      #1;
      chk("t6_no_wdog_hold", 32'(tx_active), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
